// File: rtl/fifo_reader.sv
// rtl/fifo_reader.sv - Upstream FIFO pop engine with 3-entry skid buffer feeding a valid/ready stream
//
// Purpose:
//   Pops an upstream FIFO that has registered read data (word valid the cycle
//   after the pop) and re-presents the words, in order, on a valid/ready
//   stream. Pops are issued only while the buffer plus the word still in
//   flight from the FIFO read register leave room, so the 3-entry buffer can
//   never overflow even if the consumer stalls at any time.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   fifo_empty in   upstream FIFO empty flag
//   fifo_pop   out  pop request to upstream FIFO
//   fifo_data  in   upstream read data, valid the cycle after an accepted pop
//   m_valid    out  downstream stream valid
//   m_ready    in   downstream stream ready
//   m_data     out  downstream stream data (buffer head)
//   xfer_count out  16-bit wrapping count of accepted transfers
//                   (present only with FIFO_READER_STATS_EN)
//
// Build option:
//   FIFO_READER_STATS_EN - adds the xfer_count output and its counter.

module fifo_reader #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  output logic             fifo_pop,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
`ifdef FIFO_READER_STATS_EN
  ,
  output logic [15:0]      xfer_count
`endif
);

  logic [WIDTH-1:0] mem [3];
  logic [1:0]       occ;
  logic [1:0]       rd_ptr;
  logic [1:0]       wr_ptr;
  logic             inflight;
  logic [2:0]       committed;
  logic             capture;
  logic             consume;

  // Pointers index a 3-entry ring, so they wrap 2 -> 0 rather than at 3.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Slots already spoken for: words held plus the word on its way from the
  // FIFO read register. m_ready is deliberately left out so that fifo_pop
  // has no combinational dependence on the downstream consumer.
  assign committed = {1'b0, occ} + {2'b00, inflight};
  assign fifo_pop  = !fifo_empty && (committed < 3'd3) && !rst;

  assign capture = inflight;
  assign consume = m_valid && m_ready;

  // Head comes straight from the buffer registers; fifo_data never reaches
  // the stream outputs without passing through the buffer first.
  assign m_valid = (occ != 2'd0);
  assign m_data  = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ      <= 2'd0;
      rd_ptr   <= 2'd0;
      wr_ptr   <= 2'd0;
      inflight <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        mem[i] <= '0;
      end
    end else begin
      inflight <= fifo_pop;

      if (capture) begin
        mem[wr_ptr] <= fifo_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end

      if (consume) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end

      // Capture and consume on the same edge cancel out in the occupancy.
      if (capture && !consume) begin
        occ <= occ + 2'd1;
      end else if (!capture && consume) begin
        occ <= occ - 2'd1;
      end
    end
  end

`ifdef FIFO_READER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_count <= 16'd0;
    end else if (consume) begin
      xfer_count <= xfer_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// tb/tb_fifo_reader.sv - Self-checking bench for fifo_reader

module tb_fifo_reader;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] w;
    int           avail;
  } ent_t;

  logic         clk;
  logic         rst;
  logic         fifo_empty;
  logic         fifo_pop;
  logic [W-1:0] fifo_data;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_data;
`ifdef FIFO_READER_STATS_EN
  logic [15:0]  xfer_count;
`endif

  fifo_reader #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_pop   (fifo_pop),
    .fifo_data  (fifo_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data)
`ifdef FIFO_READER_STATS_EN
    ,
    .xfer_count (xfer_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  // Upstream FIFO contents and its read register.
  logic [W-1:0] src [$];
  logic         pend_ok;
  logic [W-1:0] pend_w;
  logic         r_rst;
  logic         r_rdy;

  // Model: every popped word not yet delivered, with the first cycle it may
  // appear on the stream (pop cycle + 2).
  ent_t         mq [$];
  int           cyc_n = 0;
  logic [W-1:0] log_q [$];
  int           log_cyc [$];
  int           pop_cnt = 0;
  int           first_pop = -1;
  int           first_valid = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: apply inputs mid-cycle, then act as the FIFO for a pop.
  task automatic cyc();
    @(negedge clk);
    rst        = r_rst;
    m_ready    = r_rdy;
    fifo_data  = pend_ok ? pend_w : W'($urandom);
    fifo_empty = (src.size() == 0);
    #3;
    pend_ok = fifo_pop;
    if (fifo_pop && src.size() > 0) pend_w = src.pop_front();
  endtask

  task automatic clear_logs();
    log_q.delete();
    log_cyc.delete();
    pop_cnt     = 0;
    first_pop   = -1;
    first_valid = -1;
  endtask

  // Compare process: checks DUT outputs against the model every cycle.
  always @(negedge clk) begin
    logic ep;
    logic ev;
    #1;
    cyc_n++;
    if (rst) begin
      mq.delete();
      chk("rst_pop", fifo_pop, 0);
      chk("rst_valid", m_valid, 0);
      chk("rst_data", m_data, 0);
    end else begin
      ep = !fifo_empty && (mq.size() < 3);
      ev = (mq.size() > 0) && (mq[0].avail <= cyc_n);
      chk("pop", fifo_pop, ep);
      chk("valid", m_valid, ev);
      if (ev) chk("data", m_data, mq[0].w);
      if (fifo_pop) begin
        pop_cnt++;
        if (first_pop < 0) first_pop = cyc_n;
      end
      if (m_valid && first_valid < 0) first_valid = cyc_n;
      if (ev && m_ready) begin
        log_q.push_back(mq[0].w);
        log_cyc.push_back(cyc_n);
        void'(mq.pop_front());
      end
      if (fifo_pop && src.size() > 0) mq.push_back('{w: src[0], avail: cyc_n + 2});
    end
  end

  initial begin
    rst = 1'b1; m_ready = 1'b0; fifo_empty = 1'b1; fifo_data = '0;
    pend_ok = 1'b0; pend_w = '0; r_rst = 1'b1; r_rdy = 1'b0;

    // Reset state
    repeat (3) cyc();
    chk("reset_pop", fifo_pop, 0);
    chk("reset_valid", m_valid, 0);
    chk("reset_data", m_data, 0);

    // Empty FIFO after release: nothing moves
    r_rst = 1'b0; r_rdy = 1'b1;
    clear_logs();
    repeat (12) cyc();
    chk("idle_pops", pop_cnt, 0);
    chk("idle_valid", m_valid, 0);
    chk("idle_data", m_data, 0);

    // Preloaded 1..4 with m_ready high: latency 2, back-to-back delivery
    clear_logs();
    for (int i = 1; i <= 4; i++) src.push_back(W'(i));
    for (int k = 0; k < 30 && log_q.size() < 4; k++) cyc();
    chk("t2_latency", first_valid - first_pop, 2);
    chk("t2_count", log_q.size(), 4);
    if (log_q.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("t2_word", log_q[i], i + 1);
      chk("t2_b2b", log_cyc[3] - log_cyc[0], 3);
    end
    repeat (3) cyc();

    // Stalled consumer: exactly 3 pops, head held at 0x1
    clear_logs();
    r_rdy = 1'b0;
    for (int i = 1; i <= 4; i++) src.push_back(W'(i));
    repeat (8) cyc();
    chk("t3_pops", pop_cnt, 3);
    chk("t3_valid", m_valid, 1);
    chk("t3_head", m_data, 1);
    chk("t3_nopop", fifo_pop, 0);
    r_rdy = 1'b1;
    for (int k = 0; k < 30 && log_q.size() < 4; k++) cyc();
    chk("t3_count", log_q.size(), 4);
    if (log_q.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("t3_word", log_q[i], i + 1);
    end
    chk("t3_total_pops", pop_cnt, 4);
    repeat (3) cyc();

    // Random m_ready over 100 words
    clear_logs();
    for (int i = 0; i < 100; i++) src.push_back(W'(i));
    for (int k = 0; k < 2000 && log_q.size() < 100; k++) begin
      r_rdy = 1'($urandom_range(0, 1));
      cyc();
    end
    chk("t4_count", log_q.size(), 100);
    if (log_q.size() == 100) begin
      for (int i = 0; i < 100; i++) chk("t4_word", log_q[i], i);
    end
    r_rdy = 1'b1;
    repeat (3) cyc();

    // Reset mid-operation with two words held and one in flight
    clear_logs();
    r_rdy = 1'b0;
    for (int i = 0; i < 10; i++) src.push_back(W'(8'hA0 + i));
    repeat (3) cyc();
    chk("t5_pops", pop_cnt, 3);
    chk("t5_valid_pre", m_valid, 1);
    r_rst = 1'b1;
    cyc();
    chk("t5_rst_pop", fifo_pop, 0);
    chk("t5_rst_valid", m_valid, 0);
    r_rst = 1'b0; r_rdy = 1'b1;
    clear_logs();
    for (int k = 0; k < 40 && log_q.size() < 7; k++) cyc();
    repeat (5) cyc();
    chk("t5_count", log_q.size(), 7);
    if (log_q.size() == 7) begin
      for (int i = 0; i < 7; i++) chk("t5_word", log_q[i], 8'hA3 + i);
    end

`ifdef FIFO_READER_STATS_EN
    // 65537 transfers wrap the counter to 1
    r_rst = 1'b1;
    cyc();
    r_rst = 1'b0;
    clear_logs();
    for (int i = 0; i < 65537; i++) src.push_back(W'(i));
    for (int k = 0; k < 70000 && log_q.size() < 65537; k++) cyc();
    repeat (3) cyc();
    chk("t6_count", log_q.size(), 65537);
    chk("t6_xfer_count", xfer_count, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 SHALL have parameter: WIDTH, default 4, data word width in bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: fifo_empty  input  WIDTH-independent 1  upstream FIFO empty flag.
REQ-005 SHALL have port: fifo_pop  output  1  pop request to upstream FIFO.
REQ-006 SHALL have port: fifo_data  input  WIDTH  upstream FIFO registered read data, valid the cycle after an accepted pop.
REQ-007 SHALL have port: m_valid  output  1  downstream stream valid.
REQ-008 SHALL have port: m_ready  input  1  downstream stream ready.
REQ-009 SHALL have port: m_data  output  WIDTH  downstream stream data.

Function
REQ-010 SHALL hold a 3-entry in-order skid buffer (occupancy occ, 0..3) and a 1-bit in-flight flag (inflight).
REQ-011 SHALL drive fifo_pop = !fifo_empty && (occ + inflight < 3) && !rst; no combinational path from m_ready to fifo_pop.
REQ-012 SHALL set inflight on each edge to the value of fifo_pop in the preceding cycle.
REQ-013 SHALL, when inflight is 1, write fifo_data into the buffer tail on that edge.
REQ-014 SHALL drive m_valid = (occ != 0) and m_data = buffer head entry (registered, no combinational path from fifo_data).
REQ-015 SHALL remove the head entry on each edge where m_valid && m_ready.
REQ-016 SHALL, on simultaneous capture and consume, keep occ unchanged and preserve word order.
REQ-017 SHALL hold m_data and m_valid stable while m_valid && !m_ready.
REQ-018 SHALL present the first word on m_valid 2 cycles after the cycle fifo_pop first asserts (pop cycle N, capture edge N+2).
REQ-019 SHALL sustain 1 word/cycle with fifo_empty low and m_ready high continuously.
REQ-020 SHALL never overflow: occ + inflight never exceeds 3; m_ready low stops popping within 1 cycle.
REQ-021 SHALL ignore fifo_data when inflight is 0.
REQ-022 SHALL treat buffer pointers as 2-bit indices wrapping 2 -> 0.

Reset
REQ-023 SHALL, while rst is high, asynchronously clear occ, inflight, pointers, buffer contents and m_data to 0 and hold m_valid and fifo_pop at 0.
REQ-024 SHALL discard any in-flight and buffered words when rst asserts mid-operation; the first pop after release occurs in the first cycle with rst low and fifo_empty low.

Configuration
REQ-025 SHALL, with macro FIFO_READER_STATS_EN defined, add output xfer_count (16 bits), incremented on each m_valid && m_ready, wrapping 0xFFFF -> 0, cleared by rst.
REQ-026 SHALL, without FIFO_READER_STATS_EN, omit xfer_count and its logic; all other behaviour identical.

Verification
REQ-027 SHALL cover: reset release, fifo_empty high -> fifo_pop, m_valid, m_data all 0 indefinitely.
REQ-028 SHALL cover: FIFO preloaded 0x1,0x2,0x3,0x4, m_ready high -> fifo_pop in cycle N, m_valid from cycle N+2, m_data 0x1..0x4 on consecutive cycles.
REQ-029 SHALL cover: 4 words available, m_ready low -> exactly 3 pops, occ=3, m_data=0x1 held; m_ready high -> 0x1,0x2,0x3,0x4 delivered in order with no loss or duplicate.
REQ-030 SHALL cover: random m_ready toggling over 100 words 0..99 -> output sequence exactly 0..99.
REQ-031 SHALL cover: rst asserted with occ=2 and inflight=1 -> m_valid and fifo_pop 0 immediately; after release, no stale words appear.
REQ-032 SHALL cover, with FIFO_READER_STATS_EN: 65537 transfers -> xfer_count = 1.
